// File: rtl/fabric2_parbiter_pkg.sv
// Shared OCP command/response codes and fabric2 arbiter state encodings.
package fabric2_parbiter_pkg;

    localparam int unsigned MCMD_W  = 3;
    localparam int unsigned SRESP_W = 2;
    localparam int unsigned STATE_W = 2;

    localparam logic [MCMD_W-1:0] CMD_IDLE  = 3'b000;
    localparam logic [MCMD_W-1:0] CMD_WRITE = 3'b001;
    localparam logic [MCMD_W-1:0] CMD_READ  = 3'b010;

    localparam logic [SRESP_W-1:0] RESP_NULL = 2'b00;
    localparam logic [SRESP_W-1:0] RESP_DVA  = 2'b01;
    localparam logic [SRESP_W-1:0] RESP_FAIL = 2'b10;
    localparam logic [SRESP_W-1:0] RESP_ERR  = 2'b11;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_CMD  = 2'd1;
    localparam logic [STATE_W-1:0] ST_RESP = 2'd2;

    // Reads always wait for SResp; writes (any non-IDLE, non-READ code) only when wr_resp is set.
    function automatic logic cmd_needs_resp(input logic [MCMD_W-1:0] cmd, input logic wr_resp);
        return (cmd == CMD_READ) || ((cmd != CMD_IDLE) && wr_resp);
    endfunction

endpackage

// File: rtl/fabric2_parbiter_if.sv
// Decoded master commands, slave accept/response and the arbiter's select/status outputs.
interface fabric2_parbiter_if;

    logic [fabric2_parbiter_pkg::MCMD_W-1:0]  i_I_MCmd;
    logic [fabric2_parbiter_pkg::MCMD_W-1:0]  i_D_MCmd;
    logic                                     i_P_SCmdAccept;
    logic [fabric2_parbiter_pkg::SRESP_W-1:0] i_P_SResp;
    logic                                     o_port_sel;
    logic                                     o_busy;
    logic                                     o_timeout;

    modport master (
        output i_I_MCmd, i_D_MCmd, i_P_SCmdAccept, i_P_SResp,
        input  o_port_sel, o_busy, o_timeout
    );

    modport slave (
        input  i_I_MCmd, i_D_MCmd, i_P_SCmdAccept, i_P_SResp,
        output o_port_sel, o_busy, o_timeout
    );

endinterface

// File: rtl/fabric2_parbiter_wdog.sv
// Loadable up-counter; tc_c flags the last allowed cycle of a transaction.
module fabric2_parbiter_wdog #(
    parameter int unsigned TIMEOUT  = 0,
    parameter int unsigned TO_WIDTH = 16
) (
    input  logic clk,
    input  logic nrst,
    input  logic clr,
    input  logic en,
    output logic tc_c
);

    logic [TO_WIDTH-1:0] wd_q;
    logic [TO_WIDTH-1:0] wd_d;

    always_comb begin
        wd_d = wd_q;
        if (clr) begin
            wd_d = '0;
        end else if (en) begin
            wd_d = wd_q + TO_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

    assign tc_c = (TIMEOUT != 0) && en && (wd_q == TO_WIDTH'(TIMEOUT - 1));

endmodule

// File: rtl/fabric2_parbiter.sv
// Per-slave-port I/D arbiter: holds the grant from command issue until completion or watchdog abort.
module fabric2_parbiter
    import fabric2_parbiter_pkg::*;
#(
    parameter bit          WR_RESP  = 1'b0,
    parameter int unsigned TIMEOUT  = 0,
    parameter int unsigned TO_WIDTH = 16
) (
    input  logic               clk,
    input  logic               nrst,
    fabric2_parbiter_if.slave  bus
);

    logic [STATE_W-1:0] state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_q,  last_d;

    logic               req_i, req_d;
    logic               gnt_vld, gnt;
    logic [MCMD_W-1:0]  cur_cmd;
    logic               acc, resp_vld, cmd_done;
    logic               wd_clr, wd_en, wd_tc;
    logic               timeout_c;

    // Round-robin grant used only in IDLE: on contention the master not granted last wins.
    always_comb begin
        req_i   = (bus.i_I_MCmd != CMD_IDLE);
        req_d   = (bus.i_D_MCmd != CMD_IDLE);
        gnt_vld = req_i || req_d;
        gnt     = req_d && (!req_i || !last_q);
    end

    // Completion is judged on the command of the grantee (IDLE) or the current owner (CMD).
    always_comb begin
        if (state_q == ST_IDLE) begin
            cur_cmd = gnt ? bus.i_D_MCmd : bus.i_I_MCmd;
        end else begin
            cur_cmd = owner_q ? bus.i_D_MCmd : bus.i_I_MCmd;
        end
        acc      = bus.i_P_SCmdAccept && (cur_cmd != CMD_IDLE);
        resp_vld = (bus.i_P_SResp != RESP_NULL);
        cmd_done = acc && (!cmd_needs_resp(cur_cmd, WR_RESP) || resp_vld);
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        timeout_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    owner_d = gnt;
                    last_d  = gnt;
                    if (cmd_done) begin
                        state_d = ST_IDLE;
                    end else if (acc) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_CMD;
                    end
                end
            end
            ST_CMD: begin
                if (cmd_done) begin
                    state_d = ST_IDLE;
                end else if (acc) begin
                    state_d = ST_RESP;
                end else if (wd_tc) begin
                    state_d   = ST_IDLE;
                    timeout_c = 1'b1;
                end
            end
            ST_RESP: begin
                if (resp_vld) begin
                    state_d = ST_IDLE;
                end else if (wd_tc) begin
                    state_d   = ST_IDLE;
                    timeout_c = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Watchdog restarts on every entry into CMD or RESP and counts while busy.
    always_comb begin
        wd_clr = (state_d != ST_IDLE) && (state_d != state_q);
        wd_en  = (state_q != ST_IDLE);
    end

    fabric2_parbiter_wdog #(
        .TIMEOUT  (TIMEOUT),
        .TO_WIDTH (TO_WIDTH)
    ) u_wdog (
        .clk  (clk),
        .nrst (nrst),
        .clr  (wd_clr),
        .en   (wd_en),
        .tc_c (wd_tc)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    assign bus.o_port_sel = ((state_q == ST_IDLE) && gnt_vld) ? gnt : owner_q;
    assign bus.o_busy     = (state_q != ST_IDLE);
    assign bus.o_timeout  = timeout_c;

endmodule

// File: tb/tb_fabric2_parbiter.sv
// Directed bench: three arbiter configurations driven from the same master/slave stimulus.
module tb_fabric2_parbiter;
    import fabric2_parbiter_pkg::*;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic [2:0] i_cmd = CMD_IDLE;
    logic [2:0] d_cmd = CMD_IDLE;
    logic       acc   = 1'b0;
    logic [1:0] resp  = RESP_NULL;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fabric2_parbiter_if if_a ();
    fabric2_parbiter_if if_b ();
    fabric2_parbiter_if if_c ();

    assign if_a.i_I_MCmd = i_cmd;  assign if_a.i_D_MCmd = d_cmd;
    assign if_a.i_P_SCmdAccept = acc;  assign if_a.i_P_SResp = resp;
    assign if_b.i_I_MCmd = i_cmd;  assign if_b.i_D_MCmd = d_cmd;
    assign if_b.i_P_SCmdAccept = acc;  assign if_b.i_P_SResp = resp;
    assign if_c.i_I_MCmd = i_cmd;  assign if_c.i_D_MCmd = d_cmd;
    assign if_c.i_P_SCmdAccept = acc;  assign if_c.i_P_SResp = resp;

    // a: writes done on accept, no watchdog; b: writes wait for SResp; c: TIMEOUT = 4
    fabric2_parbiter #(.WR_RESP(1'b0), .TIMEOUT(0), .TO_WIDTH(16)) dut_a (
        .clk(clk), .nrst(nrst), .bus(if_a.slave));
    fabric2_parbiter #(.WR_RESP(1'b1), .TIMEOUT(0), .TO_WIDTH(16)) dut_b (
        .clk(clk), .nrst(nrst), .bus(if_b.slave));
    fabric2_parbiter #(.WR_RESP(1'b0), .TIMEOUT(4), .TO_WIDTH(8)) dut_c (
        .clk(clk), .nrst(nrst), .bus(if_c.slave));

    task automatic check(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] ic, input logic [2:0] dc,
                         input logic a, input logic [1:0] r);
        i_cmd = ic; d_cmd = dc; acc = a; resp = r;
    endtask

    task automatic to_sample();
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(CMD_IDLE, CMD_IDLE, 1'b0, RESP_NULL);
        nrst = 1'b0;
        @(posedge clk);
        #1;
        nrst = 1'b1;
    endtask

    initial begin
        // Reset values
        do_reset();
        to_sample();
        check("rst_sel_a",  if_a.o_port_sel, 1'b0);
        check("rst_busy_a", if_a.o_busy,     1'b0);
        check("rst_to_c",   if_c.o_timeout,  1'b0);
        check("rst_busy_b", if_b.o_busy,     1'b0);
        next_cycle();

        // Only D reads: accept cycle 0, DVA cycle 2
        drive(CMD_IDLE, CMD_READ, 1'b1, RESP_NULL);
        to_sample();
        check("t1_c0_sel",  if_a.o_port_sel, 1'b1);
        check("t1_c0_busy", if_a.o_busy,     1'b0);
        next_cycle();
        drive(CMD_IDLE, CMD_IDLE, 1'b0, RESP_NULL);
        to_sample();
        check("t1_c1_sel",  if_a.o_port_sel, 1'b1);
        check("t1_c1_busy", if_a.o_busy,     1'b1);
        next_cycle();
        drive(CMD_IDLE, CMD_IDLE, 1'b0, RESP_DVA);
        to_sample();
        check("t1_c2_sel",  if_a.o_port_sel, 1'b1);
        check("t1_c2_busy", if_a.o_busy,     1'b1);
        next_cycle();
        drive(CMD_IDLE, CMD_IDLE, 1'b0, RESP_NULL);
        to_sample();
        check("t1_c3_busy", if_a.o_busy,     1'b0);
        check("t1_c3_sel",  if_a.o_port_sel, 1'b1);
        next_cycle();

        // Contention after reset: I first, then D after a one-cycle bubble
        do_reset();
        drive(CMD_READ, CMD_READ, 1'b1, RESP_NULL);
        to_sample();
        check("t2_c0_sel",  if_a.o_port_sel, 1'b0);
        check("t2_c0_busy", if_a.o_busy,     1'b0);
        next_cycle();
        drive(CMD_IDLE, CMD_READ, 1'b0, RESP_DVA);
        to_sample();
        check("t2_c1_sel",  if_a.o_port_sel, 1'b0);
        check("t2_c1_busy", if_a.o_busy,     1'b1);
        next_cycle();
        drive(CMD_IDLE, CMD_READ, 1'b1, RESP_DVA);
        to_sample();
        check("t2_c2_sel",  if_a.o_port_sel, 1'b1);
        check("t2_c2_busy", if_a.o_busy,     1'b0);
        next_cycle();
        drive(CMD_IDLE, CMD_IDLE, 1'b0, RESP_NULL);
        to_sample();
        check("t2_c3_busy", if_a.o_busy,     1'b0);
        check("t2_c3_sel",  if_a.o_port_sel, 1'b1);
        next_cycle();

        // I writes with accept in cycle 0: done at once unless WR_RESP
        do_reset();
        drive(CMD_WRITE, CMD_IDLE, 1'b1, RESP_NULL);
        to_sample();
        check("t3_c0_sel",    if_a.o_port_sel, 1'b0);
        check("t3_c0_busy",   if_a.o_busy,     1'b0);
        next_cycle();
        drive(CMD_IDLE, CMD_IDLE, 1'b0, RESP_NULL);
        to_sample();
        check("t3_c1_busy_a", if_a.o_busy,     1'b0);
        check("t3_c1_busy_b", if_b.o_busy,     1'b1);
        next_cycle();

        // WR_RESP = 1: write waits for DVA in cycle 3 while D is held off
        do_reset();
        drive(CMD_WRITE, CMD_IDLE, 1'b1, RESP_NULL);
        to_sample();
        check("t4_c0_sel",  if_b.o_port_sel, 1'b0);
        next_cycle();
        drive(CMD_IDLE, CMD_READ, 1'b0, RESP_NULL);
        to_sample();
        check("t4_c1_sel",  if_b.o_port_sel, 1'b0);
        check("t4_c1_busy", if_b.o_busy,     1'b1);
        next_cycle();
        to_sample();
        check("t4_c2_sel",  if_b.o_port_sel, 1'b0);
        check("t4_c2_busy", if_b.o_busy,     1'b1);
        next_cycle();
        drive(CMD_IDLE, CMD_READ, 1'b0, RESP_DVA);
        to_sample();
        check("t4_c3_sel",  if_b.o_port_sel, 1'b0);
        check("t4_c3_busy", if_b.o_busy,     1'b1);
        next_cycle();
        drive(CMD_IDLE, CMD_READ, 1'b0, RESP_NULL);
        to_sample();
        check("t4_c4_busy", if_b.o_busy,     1'b0);
        check("t4_c4_sel",  if_b.o_port_sel, 1'b1);
        next_cycle();
        drive(CMD_IDLE, CMD_READ, 1'b1, RESP_ERR);
        to_sample();
        check("t4_c5_busy", if_b.o_busy,     1'b1);
        check("t4_c5_sel",  if_b.o_port_sel, 1'b1);
        next_cycle();
        drive(CMD_IDLE, CMD_IDLE, 1'b0, RESP_NULL);
        to_sample();
        check("t4_c6_busy", if_b.o_busy,     1'b0);
        next_cycle();

        // TIMEOUT = 4: D read accepted, no response; pending I wins afterwards
        do_reset();
        drive(CMD_IDLE, CMD_READ, 1'b1, RESP_NULL);
        to_sample();
        check("t5_c0_sel", if_c.o_port_sel, 1'b1);
        next_cycle();
        drive(CMD_WRITE, CMD_IDLE, 1'b0, RESP_NULL);
        to_sample();
        check("t5_c1_to",  if_c.o_timeout,  1'b0);
        next_cycle();
        to_sample();
        check("t5_c2_to",  if_c.o_timeout,  1'b0);
        next_cycle();
        to_sample();
        check("t5_c3_to",  if_c.o_timeout,  1'b0);
        check("t5_c3_sel", if_c.o_port_sel, 1'b1);
        next_cycle();
        to_sample();
        check("t5_c4_to",   if_c.o_timeout, 1'b1);
        check("t5_c4_busy", if_c.o_busy,    1'b1);
        next_cycle();
        to_sample();
        check("t5_c5_to",     if_c.o_timeout,  1'b0);
        check("t5_c5_busy",   if_c.o_busy,     1'b0);
        check("t5_c5_sel",    if_c.o_port_sel, 1'b0);
        check("t5_c5_busy_a", if_a.o_busy,     1'b1);
        next_cycle();

        // Asynchronous reset while in RESP, then first contention goes to I
        do_reset();
        drive(CMD_IDLE, CMD_READ, 1'b1, RESP_NULL);
        next_cycle();
        drive(CMD_IDLE, CMD_IDLE, 1'b0, RESP_NULL);
        to_sample();
        check("t6_pre_busy", if_a.o_busy,     1'b1);
        check("t6_pre_sel",  if_a.o_port_sel, 1'b1);
        nrst = 1'b0;
        #1;
        check("t6_rst_busy", if_a.o_busy,     1'b0);
        check("t6_rst_sel",  if_a.o_port_sel, 1'b0);
        check("t6_rst_to",   if_a.o_timeout,  1'b0);
        next_cycle();
        nrst = 1'b1;
        drive(CMD_READ, CMD_READ, 1'b0, RESP_NULL);
        to_sample();
        check("t6_post_sel", if_a.o_port_sel, 1'b0);
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
